// File: rtl/command_fetch_decoder_pkg.sv
// Shared definitions for the executor command front end: opcode names,
// default command-set shape and the fetch state encoding.
package command_fetch_decoder_pkg;

  localparam int CMD_COUNT_DEFAULT = 16;

  // Bit i set: opcode i+1 is followed by an operand.
  localparam logic [CMD_COUNT_DEFAULT-1:0] HAS_OPERAND_DEFAULT = 16'h00F0;

  localparam logic [7:0] CMD_NOP   = 8'h01;
  localparam logic [7:0] CMD_HALT  = 8'h02;
  localparam logic [7:0] CMD_SYNC  = 8'h03;
  localparam logic [7:0] CMD_FLUSH = 8'h04;
  localparam logic [7:0] CMD_LOAD  = 8'h05;
  localparam logic [7:0] CMD_STORE = 8'h06;
  localparam logic [7:0] CMD_JUMP  = 8'h07;
  localparam logic [7:0] CMD_WAIT  = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPERAND = 2'd1,
    ST_ISSUE   = 2'd2
  } state_t;

endpackage

// File: rtl/command_fetch_decoder_if.sv
// Byte-stream input and command-presentation output of the fetch decoder.
interface command_fetch_decoder_if
  import command_fetch_decoder_pkg::*;
#(
  parameter int OPCODE_WIDTH  = 8,
  parameter int CMD_COUNT     = CMD_COUNT_DEFAULT,
  parameter int OPERAND_BYTES = 4
);

  logic [OPCODE_WIDTH-1:0]               byte_in;
  logic                                  byte_valid;
  logic                                  byte_ready;
  logic                                  abort;
  logic [CMD_COUNT-1:0]                  cmd_onehot;
  logic [OPERAND_BYTES*OPCODE_WIDTH-1:0] cmd_operand;
  logic                                  cmd_valid;
  logic                                  cmd_ack;
  logic                                  illegal_opcode;
  logic                                  busy;

  modport master (
    output byte_in, byte_valid, abort, cmd_ack,
    input  byte_ready, cmd_onehot, cmd_operand, cmd_valid, illegal_opcode, busy
  );

  modport slave (
    input  byte_in, byte_valid, abort, cmd_ack,
    output byte_ready, cmd_onehot, cmd_operand, cmd_valid, illegal_opcode, busy
  );

endinterface

// File: rtl/command_fetch_decoder_opcode_onehot.sv
// Combinational opcode decode: one-hot of (opcode-1) and a legality flag.
module opcode_onehot #(
  parameter int OPCODE_WIDTH = 8,
  parameter int CMD_COUNT    = 16
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [CMD_COUNT-1:0]    onehot,
  output logic                    legal
);

  always_comb begin
    // NOTE: default every output first so no path through the block infers a latch.
    onehot = '0;
    for (int i = 0; i < CMD_COUNT; i++) begin
      onehot[i] = (opcode == OPCODE_WIDTH'(i + 1));
    end
  end

  // Opcode 0 and anything above CMD_COUNT match no bit.
  assign legal = |onehot;

endmodule

// File: rtl/command_fetch_decoder.sv
// Registered command front end: validates opcodes, assembles little-endian
// operands and presents a one-hot command under a valid/ack handshake.
module command_fetch_decoder
  import command_fetch_decoder_pkg::*;
#(
  parameter int                   OPCODE_WIDTH  = 8,
  parameter int                   CMD_COUNT     = CMD_COUNT_DEFAULT,
  parameter int                   OPERAND_BYTES = 4,
  parameter logic [CMD_COUNT-1:0] HAS_OPERAND   = CMD_COUNT'(HAS_OPERAND_DEFAULT)
) (
  input logic                    clk,
  input logic                    reset,
  command_fetch_decoder_if.slave bus
);

  localparam int CW = $clog2(OPERAND_BYTES + 1);

  state_t               state;
  logic [CW-1:0]        count;
  logic [CMD_COUNT-1:0] pend_onehot;
  logic [CMD_COUNT-1:0] dec_onehot;
  logic                 dec_legal;
  logic                 dec_has_operand;
  logic                 accept;

  opcode_onehot #(
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .CMD_COUNT    (CMD_COUNT)
  ) u_opcode_onehot (
    .opcode (bus.byte_in),
    .onehot (dec_onehot),
    .legal  (dec_legal)
  );

  assign dec_has_operand = |(dec_onehot & HAS_OPERAND);

  // Decoded from the state register only, so no input reaches an output combinationally.
  assign bus.byte_ready = (state != ST_ISSUE);
  assign bus.busy       = (state != ST_IDLE);
  assign accept         = bus.byte_valid && bus.byte_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= ST_IDLE;
      count              <= '0;
      pend_onehot        <= '0;
      bus.cmd_onehot     <= '0;
      bus.cmd_operand    <= '0;
      bus.cmd_valid      <= 1'b0;
      bus.illegal_opcode <= 1'b0;
    end else begin
      bus.illegal_opcode <= 1'b0;
      if (bus.abort) begin
        state           <= ST_IDLE;
        count           <= '0;
        pend_onehot     <= '0;
        bus.cmd_onehot  <= '0;
        bus.cmd_operand <= '0;
        bus.cmd_valid   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              if (!dec_legal) begin
                bus.illegal_opcode <= 1'b1;
              end else if (dec_has_operand) begin
                state           <= ST_OPERAND;
                count           <= '0;
                pend_onehot     <= dec_onehot;
                bus.cmd_operand <= '0;
              end else begin
                state           <= ST_ISSUE;
                bus.cmd_valid   <= 1'b1;
                bus.cmd_onehot  <= dec_onehot;
                bus.cmd_operand <= '0;
              end
            end
          end

          ST_OPERAND: begin
            if (accept) begin
              for (int k = 0; k < OPERAND_BYTES; k++) begin
                if (count == CW'(k)) begin
                  bus.cmd_operand[k*OPCODE_WIDTH +: OPCODE_WIDTH] <= bus.byte_in;
                end
              end
              if (count == CW'(OPERAND_BYTES - 1)) begin
                state          <= ST_ISSUE;
                count          <= '0;
                bus.cmd_valid  <= 1'b1;
                bus.cmd_onehot <= pend_onehot;
              end else begin
                count <= count + 1'b1;
              end
            end
          end

          ST_ISSUE: begin
            if (bus.cmd_ack) begin
              state           <= ST_IDLE;
              pend_onehot     <= '0;
              bus.cmd_valid   <= 1'b0;
              bus.cmd_onehot  <= '0;
              bus.cmd_operand <= '0;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_command_fetch_decoder.sv
// Scoreboard bench for command_fetch_decoder: default instance plus a
// 32-command / 2-operand-byte instance.
module tb_command_fetch_decoder;

  typedef struct {
    logic [15:0] oh;
    logic [31:0] op;
  } exp0_t;

  typedef struct {
    logic [31:0] oh;
    logic [15:0] op;
  } exp1_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;

  exp0_t exp0_q[$];
  exp1_t exp1_q[$];
  logic  prev_v0;
  logic  prev_v1;

  command_fetch_decoder_if #(.OPCODE_WIDTH(8), .CMD_COUNT(16), .OPERAND_BYTES(4)) bus0 ();
  command_fetch_decoder_if #(.OPCODE_WIDTH(8), .CMD_COUNT(32), .OPERAND_BYTES(2)) bus1 ();

  command_fetch_decoder #(
    .OPCODE_WIDTH(8), .CMD_COUNT(16), .OPERAND_BYTES(4), .HAS_OPERAND(16'h00F0)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  command_fetch_decoder #(
    .OPCODE_WIDTH(8), .CMD_COUNT(32), .OPERAND_BYTES(2), .HAS_OPERAND(32'h8000_00F0)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard: compare each command on the first cycle it is presented.
  always @(negedge clk) begin
    if (bus0.cmd_valid === 1'b1 && prev_v0 !== 1'b1) begin
      n_checks++;
      if (exp0_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb0_unexpected: got onehot=%h operand=%h, wanted no command",
                 bus0.cmd_onehot, bus0.cmd_operand);
      end else begin
        exp0_t e;
        e = exp0_q.pop_front();
        if ({bus0.cmd_onehot, bus0.cmd_operand} !== {e.oh, e.op}) begin
          n_fail++;
          $display("FAIL sb0_cmd: got onehot=%h operand=%h, wanted onehot=%h operand=%h",
                   bus0.cmd_onehot, bus0.cmd_operand, e.oh, e.op);
        end
      end
    end
    prev_v0 = bus0.cmd_valid;
  end

  always @(negedge clk) begin
    if (bus1.cmd_valid === 1'b1 && prev_v1 !== 1'b1) begin
      n_checks++;
      if (exp1_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb1_unexpected: got onehot=%h operand=%h, wanted no command",
                 bus1.cmd_onehot, bus1.cmd_operand);
      end else begin
        exp1_t e;
        e = exp1_q.pop_front();
        if ({bus1.cmd_onehot, bus1.cmd_operand} !== {e.oh, e.op}) begin
          n_fail++;
          $display("FAIL sb1_cmd: got onehot=%h operand=%h, wanted onehot=%h operand=%h",
                   bus1.cmd_onehot, bus1.cmd_operand, e.oh, e.op);
        end
      end
    end
    prev_v1 = bus1.cmd_valid;
  end

  // Drivers: called at a falling edge, return at the next falling edge.
  task automatic send0(input logic [7:0] b);
    bus0.byte_in    = b;
    bus0.byte_valid = 1'b1;
    @(negedge clk);
    bus0.byte_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b);
    bus1.byte_in    = b;
    bus1.byte_valid = 1'b1;
    @(negedge clk);
    bus1.byte_valid = 1'b0;
  endtask

  task automatic ack0();
    bus0.cmd_ack = 1'b1;
    @(negedge clk);
    bus0.cmd_ack = 1'b0;
  endtask

  task automatic ack1();
    bus1.cmd_ack = 1'b1;
    @(negedge clk);
    bus1.cmd_ack = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus0.byte_ready, bus0.busy, bus0.cmd_valid, bus0.illegal_opcode} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got ready/busy/valid/illegal=%b, wanted 1000",
               {bus0.byte_ready, bus0.busy, bus0.cmd_valid, bus0.illegal_opcode});
    end
    n_checks++;
    if ({bus0.cmd_onehot, bus0.cmd_operand} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_data: got onehot=%h operand=%h, wanted 0",
               bus0.cmd_onehot, bus0.cmd_operand);
    end
    n_checks++;
    if ({bus1.byte_ready, bus1.busy, bus1.cmd_valid, bus1.cmd_onehot} !== {3'b100, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_wide: got ready=%b busy=%b valid=%b onehot=%h, wanted 1 0 0 0",
               bus1.byte_ready, bus1.busy, bus1.cmd_valid, bus1.cmd_onehot);
    end
  endtask

  task automatic test_no_operand();
    exp0_q.push_back('{16'h0004, 32'h0});
    send0(8'h03);
    n_checks++;
    if (bus0.cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL no_op_latency: got cmd_valid=%b one cycle after opcode, wanted 1", bus0.cmd_valid);
    end
    // A byte offered during ISSUE must be refused.
    bus0.byte_in    = 8'h01;
    bus0.byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bus0.cmd_valid, bus0.byte_ready, bus0.busy, bus0.cmd_onehot, bus0.cmd_operand}
          !== {3'b101, 16'h0004, 32'h0}) begin
        n_fail++;
        $display("FAIL no_op_hold%0d: got valid=%b ready=%b busy=%b onehot=%h operand=%h, wanted 1 0 1 0004 0",
                 i, bus0.cmd_valid, bus0.byte_ready, bus0.busy, bus0.cmd_onehot, bus0.cmd_operand);
      end
      @(negedge clk);
    end
    bus0.byte_valid = 1'b0;
    ack0();
    n_checks++;
    if ({bus0.cmd_valid, bus0.byte_ready, bus0.busy, bus0.cmd_onehot} !== {3'b010, 16'h0}) begin
      n_fail++;
      $display("FAIL no_op_ack: got valid=%b ready=%b busy=%b onehot=%h, wanted 0 1 0 0",
               bus0.cmd_valid, bus0.byte_ready, bus0.busy, bus0.cmd_onehot);
    end
  endtask

  task automatic test_operand(input bit gap);
    int start;
    int lat;
    exp0_q.push_back('{16'h0020, 32'h4433_2211});
    start = cyc;
    send0(8'h06);
    send0(8'h11);
    send0(8'h22);
    if (gap) begin
      @(negedge clk);
      n_checks++;
      if ({bus0.busy, bus0.cmd_valid, bus0.byte_ready} !== 3'b101) begin
        n_fail++;
        $display("FAIL operand_gap_state: got busy=%b valid=%b ready=%b, wanted 1 0 1",
                 bus0.busy, bus0.cmd_valid, bus0.byte_ready);
      end
    end
    send0(8'h33);
    n_checks++;
    if (bus0.cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL operand_early: got cmd_valid=%b before last byte, wanted 0", bus0.cmd_valid);
    end
    send0(8'h44);
    lat = cyc - start;
    n_checks++;
    if (bus0.cmd_valid !== 1'b1 || lat != (gap ? 6 : 5)) begin
      n_fail++;
      $display("FAIL operand_latency(gap=%0d): got valid=%b after %0d edges, wanted 1 after %0d",
               gap, bus0.cmd_valid, lat, gap ? 6 : 5);
    end
    ack0();
  endtask

  task automatic test_illegal();
    logic [7:0] bad [3];
    bad[0] = 8'h00;
    bad[1] = 8'h11;
    bad[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      bus0.byte_in    = bad[i];
      bus0.byte_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus0.illegal_opcode, bus0.cmd_valid, bus0.busy, bus0.byte_ready} !== 4'b1001) begin
        n_fail++;
        $display("FAIL illegal_%h: got illegal=%b valid=%b busy=%b ready=%b, wanted 1 0 0 1",
                 bad[i], bus0.illegal_opcode, bus0.cmd_valid, bus0.busy, bus0.byte_ready);
      end
    end
    bus0.byte_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus0.illegal_opcode, bus0.cmd_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL illegal_drop: got illegal=%b valid=%b, wanted 0 0",
               bus0.illegal_opcode, bus0.cmd_valid);
    end
  endtask

  task automatic test_abort();
    send0(8'h05);
    send0(8'hAA);
    send0(8'hBB);
    // Abort wins over a byte accepted on the same edge.
    bus0.byte_in    = 8'hCC;
    bus0.byte_valid = 1'b1;
    bus0.abort      = 1'b1;
    @(negedge clk);
    bus0.byte_valid = 1'b0;
    bus0.abort      = 1'b0;
    n_checks++;
    if ({bus0.busy, bus0.cmd_valid, bus0.byte_ready, bus0.cmd_operand} !== {3'b001, 32'h0}) begin
      n_fail++;
      $display("FAIL abort_operand: got busy=%b valid=%b ready=%b operand=%h, wanted 0 0 1 0",
               bus0.busy, bus0.cmd_valid, bus0.byte_ready, bus0.cmd_operand);
    end
    bus0.byte_in    = 8'h02;
    bus0.byte_valid = 1'b1;
    bus0.abort      = 1'b1;
    @(negedge clk);
    bus0.byte_valid = 1'b0;
    bus0.abort      = 1'b0;
    n_checks++;
    if ({bus0.busy, bus0.cmd_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b valid=%b, wanted 0 0", bus0.busy, bus0.cmd_valid);
    end
    exp0_q.push_back('{16'h0001, 32'h0});
    send0(8'h01);
    n_checks++;
    if ({bus0.cmd_valid, bus0.cmd_operand} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL abort_next: got valid=%b operand=%h, wanted 1 0", bus0.cmd_valid, bus0.cmd_operand);
    end
    ack0();
  endtask

  task automatic test_back_to_back();
    exp0_q.push_back('{16'h0002, 32'h0});
    exp0_q.push_back('{16'h0008, 32'h0});
    send0(8'h02);
    bus0.cmd_ack = 1'b1;
    @(negedge clk);
    // Ack stays high into IDLE, where it must be ignored.
    bus0.byte_in    = 8'h04;
    bus0.byte_valid = 1'b1;
    @(negedge clk);
    bus0.byte_valid = 1'b0;
    bus0.cmd_ack    = 1'b0;
    n_checks++;
    if ({bus0.cmd_valid, bus0.cmd_onehot} !== {1'b1, 16'h0008}) begin
      n_fail++;
      $display("FAIL b2b_second: got valid=%b onehot=%h, wanted 1 0008", bus0.cmd_valid, bus0.cmd_onehot);
    end
    ack0();
  endtask

  task automatic test_reset_issue();
    exp0_q.push_back('{16'h0004, 32'h0});
    send0(8'h03);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus0.cmd_valid, bus0.busy, bus0.byte_ready, bus0.cmd_onehot} !== {3'b001, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_async: got valid=%b busy=%b ready=%b onehot=%h, wanted 0 0 1 0",
               bus0.cmd_valid, bus0.busy, bus0.byte_ready, bus0.cmd_onehot);
    end
    @(negedge clk);
    reset = 1'b0;
    exp0_q.push_back('{16'h0001, 32'h0});
    send0(8'h01);
    n_checks++;
    if ({bus0.cmd_valid, bus0.cmd_onehot} !== {1'b1, 16'h0001}) begin
      n_fail++;
      $display("FAIL reset_first_accept: got valid=%b onehot=%h, wanted 1 0001",
               bus0.cmd_valid, bus0.cmd_onehot);
    end
    ack0();
  endtask

  task automatic test_wide();
    exp1_q.push_back('{32'h8000_0000, 16'hCDAB});
    send1(8'h20);
    send1(8'hAB);
    send1(8'hCD);
    n_checks++;
    if ({bus1.cmd_valid, bus1.cmd_onehot, bus1.cmd_operand} !== {1'b1, 32'h8000_0000, 16'hCDAB}) begin
      n_fail++;
      $display("FAIL wide_cmd: got valid=%b onehot=%h operand=%h, wanted 1 80000000 cdab",
               bus1.cmd_valid, bus1.cmd_onehot, bus1.cmd_operand);
    end
    ack1();
    send1(8'h21);
    n_checks++;
    if ({bus1.illegal_opcode, bus1.busy, bus1.cmd_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL wide_illegal: got illegal=%b busy=%b valid=%b, wanted 1 0 0",
               bus1.illegal_opcode, bus1.busy, bus1.cmd_valid);
    end
  endtask

  task automatic test_drain();
    @(negedge clk);
    n_checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d commands never presented, wanted 0/0",
               exp0_q.size(), exp1_q.size());
    end
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    cyc             = 0;
    prev_v0         = 1'b0;
    prev_v1         = 1'b0;
    reset           = 1'b1;
    bus0.byte_in    = '0;
    bus0.byte_valid = 1'b0;
    bus0.abort      = 1'b0;
    bus0.cmd_ack    = 1'b0;
    bus1.byte_in    = '0;
    bus1.byte_valid = 1'b0;
    bus1.abort      = 1'b0;
    bus1.cmd_ack    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_no_operand();
    test_operand(1'b0);
    test_operand(1'b1);
    test_illegal();
    test_abort();
    test_back_to_back();
    test_reset_issue();
    test_wide();
    test_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
